// File: rtl/cpu_axi_master.sv
// cpu_axi_master: turns a single-word CPU request into one single-beat AXI4 INCR transaction, one in flight.
// Optional build macro CPU_AXI_POSTED_WRITE_EN: writes complete to the CPU before B; B errors become sticky posted_err.
module cpu_axi_master #(
  parameter logic [3:0] MASTER_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic        posted_err,
  output logic [3:0]  ARID_M,
  output logic [31:0] ARADDR_M,
  output logic [3:0]  ARLEN_M,
  output logic [2:0]  ARSIZE_M,
  output logic [1:0]  ARBURST_M,
  output logic        ARVALID_M,
  input  logic        ARREADY_M,
  input  logic [3:0]  RID_M,
  input  logic [31:0] RDATA_M,
  input  logic [1:0]  RRESP_M,
  input  logic        RLAST_M,
  input  logic        RVALID_M,
  output logic        RREADY_M,
  output logic [3:0]  AWID_M,
  output logic [31:0] AWADDR_M,
  output logic [3:0]  AWLEN_M,
  output logic [2:0]  AWSIZE_M,
  output logic [1:0]  AWBURST_M,
  output logic        AWVALID_M,
  input  logic        AWREADY_M,
  output logic [31:0] WDATA_M,
  output logic [3:0]  WSTRB_M,
  output logic        WLAST_M,
  output logic        WVALID_M,
  input  logic        WREADY_M,
  input  logic [3:0]  BID_M,
  input  logic [1:0]  BRESP_M,
  input  logic        BVALID_M,
  output logic        BREADY_M
);

  // state   | meaning
  // IDLE    | waiting for mem_req; request fields latched here
  // RD_ADDR | ARVALID high until ARREADY
  // RD_DATA | RREADY high until RVALID
  // WR_REQ  | AWVALID/WVALID high, each dropped after its own handshake
  // WR_RESP | BREADY high until BVALID
  // DONE    | one-cycle mem_done pulse with mem_err
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        aw_done_q, w_done_q, err_q;
  logic        aw_hs, w_hs, r_hs, b_hs, r_err, b_err;
  logic        early_done;
  logic        addr_lsb_unused;

  assign addr_lsb_unused = ^mem_addr[1:0];

  assign aw_hs = (state_q == WR_REQ) & ~aw_done_q & AWREADY_M;
  assign w_hs  = (state_q == WR_REQ) & ~w_done_q & WREADY_M;
  assign r_hs  = (state_q == RD_DATA) & RVALID_M;
  assign b_hs  = (state_q == WR_RESP) & BVALID_M;
  assign r_err = (RRESP_M != 2'b00) | (RID_M != MASTER_ID) | ~RLAST_M;
  assign b_err = (BRESP_M != 2'b00) | (BID_M != MASTER_ID);

  assign ARID_M    = MASTER_ID;
  assign ARADDR_M  = {addr_q, 2'b00};
  assign ARLEN_M   = 4'd0;
  assign ARSIZE_M  = 3'b010;
  assign ARBURST_M = 2'b01;
  assign AWID_M    = MASTER_ID;
  assign AWADDR_M  = {addr_q, 2'b00};
  assign AWLEN_M   = 4'd0;
  assign AWSIZE_M  = 3'b010;
  assign AWBURST_M = 2'b01;
  assign WDATA_M   = wdata_q;
  assign WSTRB_M   = wstrb_q;
  assign WLAST_M   = 1'b1;

  always_comb begin
    state_d   = state_q;
    ARVALID_M = 1'b0;
    RREADY_M  = 1'b0;
    AWVALID_M = 1'b0;
    WVALID_M  = 1'b0;
    BREADY_M  = 1'b0;
    case (state_q)
      IDLE:    if (mem_req) state_d = mem_we ? WR_REQ : RD_ADDR;
      RD_ADDR: begin
        ARVALID_M = 1'b1;
        if (ARREADY_M) state_d = RD_DATA;
      end
      RD_DATA: begin
        RREADY_M = 1'b1;
        if (RVALID_M) state_d = DONE;
      end
      WR_REQ: begin
        AWVALID_M = ~aw_done_q;
        WVALID_M  = ~w_done_q;
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_d = WR_RESP;
      end
      WR_RESP: begin
        BREADY_M = 1'b1;
`ifdef CPU_AXI_POSTED_WRITE_EN
        // CPU was already released on entry to WR_RESP
        if (BVALID_M) state_d = IDLE;
`else
        if (BVALID_M) state_d = DONE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && mem_req) begin
        addr_q  <= mem_addr[31:2];
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
      end
      if (state_q == IDLE) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
      if (r_hs) begin
        rdata_q <= RDATA_M;
        err_q   <= r_err;
      end
      if (b_hs) err_q <= b_err;
    end
  end

`ifdef CPU_AXI_POSTED_WRITE_EN
  logic posted_done_q, posted_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      posted_done_q <= 1'b0;
      posted_err_q  <= 1'b0;
    end else begin
      posted_done_q <= (state_q == WR_REQ) & (state_d == WR_RESP);
      if (b_hs & b_err) posted_err_q <= 1'b1;
    end
  end

  assign early_done = posted_done_q;
  assign posted_err = posted_err_q;
`else
  assign early_done = 1'b0;
  assign posted_err = 1'b0;
`endif

  assign mem_done  = (state_q == DONE) | early_done;
  assign mem_err   = (state_q == DONE) & err_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_cpu_axi_master.sv
// Scoreboard bench for cpu_axi_master: stimulus pushes expected completions, a negedge monitor checks each mem_done.
module tb_cpu_axi_master;
  localparam logic [3:0] MID = 4'd0;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_done, mem_err, posted_err;
  logic [31:0] mem_rdata;
  logic [3:0]  ARID_M, ARLEN_M, AWID_M, AWLEN_M, RID_M, BID_M, WSTRB_M;
  logic [31:0] ARADDR_M, AWADDR_M, RDATA_M, WDATA_M;
  logic [2:0]  ARSIZE_M, AWSIZE_M;
  logic [1:0]  ARBURST_M, AWBURST_M, RRESP_M, BRESP_M;
  logic        ARVALID_M, ARREADY_M, RLAST_M, RVALID_M, RREADY_M;
  logic        AWVALID_M, AWREADY_M, WLAST_M, WVALID_M, WREADY_M;
  logic        BVALID_M, BREADY_M;

  cpu_axi_master #(.MASTER_ID(MID)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .posted_err(posted_err),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
    .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
    .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
    .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
    .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
    .WREADY_M(WREADY_M),
    .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          req_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_rdata = 32'h0;
  logic        exp_posted_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && mem_done) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got mem_done=1 expected no completion (t=%0t)", $time);
      end else begin
        e = sb_q.pop_front();
        check("done_rdata", mem_rdata, e.rdata);
        check("done_err", 32'(mem_err), 32'(e.err));
        check("done_latency", cyc - e.req_cyc + 1, e.lat);
      end
    end
  end

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      RVALID_M = 1'b0;
      if (mem_done) begin ok = 1'b1; break; end
    end
    mem_req = 1'b0;
    check("done_seen", 32'(ok), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_wait, input logic [31:0] data,
                         input logic [1:0] resp, input logic [3:0] id, input logic last,
                         input logic exp_err);
    exp_t e;
    bit   ok;
    @(negedge clk);
    model_rdata = data;
    e.rdata = data; e.err = exp_err; e.lat = 4 + ar_wait; e.req_cyc = cyc;
    sb_q.push_back(e);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = addr;
    mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'hF; ARREADY_M = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ARVALID_M) begin ok = 1'b1; break; end
    end
    check("arvalid_seen", 32'(ok), 32'd1);
    check("araddr", ARADDR_M, {addr[31:2], 2'b00});
    check("ar_fields", 32'({ARID_M, ARLEN_M, ARSIZE_M, ARBURST_M}), 32'({MID, 4'd0, 3'b010, 2'b01}));
    for (int i = 0; i < ar_wait; i++) begin
      @(negedge clk);
      check("arvalid_hold", 32'(ARVALID_M), 32'd1);
      check("araddr_hold", ARADDR_M, {addr[31:2], 2'b00});
      check("no_done_in_ar", 32'(mem_done), 32'd0);
    end
    ARREADY_M = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ARREADY_M = 1'b0;
      if (RREADY_M) begin ok = 1'b1; break; end
    end
    check("rready_seen", 32'(ok), 32'd1);
    check("arvalid_dropped", 32'(ARVALID_M), 32'd0);
    RVALID_M = 1'b1; RDATA_M = data; RRESP_M = resp; RID_M = id; RLAST_M = last;
    wait_done();
    check("posted_err", 32'(posted_err), 32'(exp_posted_err));
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_wait, input int w_wait, input int b_wait,
                          input logic [1:0] bresp, input logic [3:0] bid, input logic exp_err);
    exp_t e;
    bit   ok, b_sent, got_done;
    int   mx, bw;
    mx = (aw_wait > w_wait) ? aw_wait : w_wait;
    @(negedge clk);
    e.rdata = model_rdata; e.req_cyc = cyc;
`ifdef CPU_AXI_POSTED_WRITE_EN
    e.err = 1'b0; e.lat = 3 + mx;
    if (exp_err) exp_posted_err = 1'b1;
`else
    e.err = exp_err; e.lat = 4 + mx + b_wait;
`endif
    sb_q.push_back(e);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = addr; mem_wdata = data; mem_wstrb = strb;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (AWVALID_M && WVALID_M) begin ok = 1'b1; break; end
    end
    check("aw_w_seen", 32'(ok), 32'd1);
    check("awaddr", AWADDR_M, {addr[31:2], 2'b00});
    check("aw_fields", 32'({AWID_M, AWLEN_M, AWSIZE_M, AWBURST_M}), 32'({MID, 4'd0, 3'b010, 2'b01}));
    check("wdata", WDATA_M, data);
    check("wstrb_wlast", 32'({WSTRB_M, WLAST_M}), 32'({strb, 1'b1}));
    for (int k = 0; k <= mx; k++) begin
      if (k > 0) @(negedge clk);
      check("awvalid", 32'(AWVALID_M), 32'(k <= aw_wait));
      check("wvalid", 32'(WVALID_M), 32'(k <= w_wait));
      check("bready_early", 32'(BREADY_M), 32'd0);
      AWREADY_M = (k == aw_wait);
      WREADY_M  = (k == w_wait);
    end
    b_sent = 1'b0; got_done = 1'b0; bw = b_wait;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      AWREADY_M = 1'b0; WREADY_M = 1'b0; BVALID_M = 1'b0;
      check("aw_w_dropped", 32'({AWVALID_M, WVALID_M}), 32'd0);
      check("no_ar_during_write", 32'(ARVALID_M), 32'd0);
      if (mem_done) begin got_done = 1'b1; mem_req = 1'b0; end
      if (got_done && b_sent) break;
      if (BREADY_M && !b_sent) begin
        if (bw == 0) begin
          BVALID_M = 1'b1; BRESP_M = bresp; BID_M = bid; b_sent = 1'b1;
        end else bw--;
      end
    end
    mem_req = 1'b0;
    check("write_complete", 32'({got_done, b_sent}), 32'b11);
    check("posted_err", 32'(posted_err), 32'(exp_posted_err));
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    ARREADY_M = 1'b0; RID_M = '0; RDATA_M = '0; RRESP_M = '0; RLAST_M = 1'b0; RVALID_M = 1'b0;
    AWREADY_M = 1'b0; WREADY_M = 1'b0; BID_M = '0; BRESP_M = '0; BVALID_M = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valids", 32'({ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M}), 32'd0);
    check("rst_done_err", 32'({mem_done, mem_err, posted_err}), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    rst = 1'b0;

    do_read(32'h0000_1006, 0, 32'hDEAD_BEEF, 2'b00, MID, 1'b1, 1'b0);
    do_write(32'h0000_2000, 32'h1234_5678, 4'b0011, 2, 0, 0, 2'b00, MID, 1'b0);
    do_read(32'h0000_3000, 5, 32'hCAFE_F00D, 2'b00, MID, 1'b1, 1'b0);
    do_read(32'h0000_0010, 0, 32'h1111_2222, 2'b10, MID, 1'b1, 1'b1);
    do_read(32'h0000_0014, 0, 32'h3333_4444, 2'b00, 4'(MID + 1), 1'b1, 1'b1);
    do_read(32'h0000_0018, 0, 32'h5555_6666, 2'b00, MID, 1'b0, 1'b1);
    do_write(32'h0000_2004, 32'hA5A5_A5A5, 4'b1111, 0, 0, 0, 2'b00, MID, 1'b0);
    do_write(32'h0000_200B, 32'h0F0F_0F0F, 4'b1100, 0, 3, 2, 2'b10, MID, 1'b1);
    do_write(32'h0000_200C, 32'h7777_8888, 4'b0001, 1, 1, 0, 2'b00, 4'(MID + 1), 1'b1);

    // reset while waiting for B
    @(negedge clk);
`ifdef CPU_AXI_POSTED_WRITE_EN
    sb_q.push_back('{rdata: model_rdata, err: 1'b0, lat: 3, req_cyc: cyc});
`endif
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_4000; mem_wdata = 32'h1; mem_wstrb = 4'hF;
    AWREADY_M = 1'b1; WREADY_M = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (BREADY_M) begin ok = 1'b1; break; end
    end
    AWREADY_M = 1'b0; WREADY_M = 1'b0; mem_req = 1'b0;
    check("bready_before_rst", 32'(ok), 32'd1);
    @(negedge clk);
    check("bready_holds", 32'(BREADY_M), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_valids", 32'({AWVALID_M, WVALID_M, BREADY_M, ARVALID_M, RREADY_M}), 32'd0);
    check("midrst_done", 32'({mem_done, posted_err}), 32'd0);
    check("midrst_rdata", mem_rdata, 32'd0);
    model_rdata = 32'h0;
    exp_posted_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    do_read(32'h0000_5000, 0, 32'h0BAD_F00D, 2'b00, MID, 1'b1, 1'b0);
    do_write(32'h0000_6000, 32'h5A5A_5A5A, 4'b1010, 0, 0, 3, 2'b11, MID, 1'b1);
    do_read(32'h0000_6000, 1, 32'h5A5A_5A5A, 2'b00, MID, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cpu_axi_master.md
Name: cpu_axi_master

Overview:
- Converts a simple single-word CPU memory request port (IM or DM side) into AXI4 master transactions.
- Sits between the CPU core and the AXI interconnect; counterpart of the SRAM slave wrapper.
- Issues one single-beat INCR transaction per request and holds the CPU until the response completes.
- One outstanding transaction at a time.

Parameters:
MASTER_ID, 4'd0, value driven on ARID_M/AWID_M and expected on RID_M/BID_M

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
mem_req  in  1  CPU request, level; held with stable fields until mem_done
mem_we  in  1  1=write, 0=read
mem_addr  in  32  byte address
mem_wdata  in  32  write data
mem_wstrb  in  4  write byte enables, active-high
mem_done  out  1  one-cycle completion pulse
mem_rdata  out  32  read data, valid with mem_done, held until next read completes
mem_err  out  1  error flag, valid with mem_done
posted_err  out  1  sticky posted-write error (see Optional Feature)
ARID_M  out  4  read address ID
ARADDR_M  out  32  read address
ARLEN_M  out  4  burst length
ARSIZE_M  out  3  transfer size
ARBURST_M  out  2  burst type
ARVALID_M  out  1  read address valid
ARREADY_M  in  1  read address ready
RID_M  in  4  read data ID
RDATA_M  in  32  read data
RRESP_M  in  2  read response
RLAST_M  in  1  last read beat
RVALID_M  in  1  read data valid
RREADY_M  out  1  read data ready
AWID_M  out  4  write address ID
AWADDR_M  out  32  write address
AWLEN_M  out  4  burst length
AWSIZE_M  out  3  transfer size
AWBURST_M  out  2  burst type
AWVALID_M  out  1  write address valid
AWREADY_M  in  1  write address ready
WDATA_M  out  32  write data
WSTRB_M  out  4  write strobes
WLAST_M  out  1  last write beat
WVALID_M  out  1  write data valid
WREADY_M  in  1  write data ready
BID_M  in  4  write response ID
BRESP_M  in  2  write response
BVALID_M  in  1  write response valid
BREADY_M  out  1  write response ready

Behaviour:
- Reset (async): state=IDLE; all VALID/READY outputs, mem_done, mem_err and posted_err are 0; mem_rdata=0; aw_done and w_done flags cleared.
  - A reset mid-transaction drops all valids immediately. The in-flight transaction is abandoned.
- Constant fields on both AR and AW:
  - LEN=0, SIZE=3'b010, BURST=2'b01 (INCR), ID=MASTER_ID.
  - ADDR={mem_addr[31:2],2'b00}; the address is word-aligned, low bits dropped.
- Request latching: addr, wdata and wstrb are latched into registers in IDLE when mem_req=1.
  - All AXI outputs are driven from these registers, so they stay stable while VALID is high.
- States:
  - IDLE: on mem_req: if mem_we=0 go RD_ADDR, else go WR_REQ.
  - RD_ADDR: ARVALID_M=1 until ARREADY_M is sampled high; then go RD_DATA. ARVALID is never withdrawn before the handshake.
  - RD_DATA: RREADY_M=1. On RVALID_M:
    - capture RDATA_M into mem_rdata;
    - err = (RRESP_M!=2'b00) | (RID_M!=MASTER_ID) | ~RLAST_M;
    - go DONE.
  - WR_REQ: AWVALID_M and WVALID_M are asserted together, with WLAST_M=1.
    - Each valid drops individually after its own handshake, recorded in the aw_done/w_done flags.
    - If both handshakes occur in the same cycle, or once both flags are set, go WR_RESP.
    - W may complete before AW.
  - WR_RESP: BREADY_M=1. On BVALID_M: err = (BRESP_M!=2'b00) | (BID_M!=MASTER_ID); go DONE.
  - DONE: mem_done=1 for exactly one cycle, with mem_err; then go IDLE.
- A new request is sampled in IDLE at the earliest one cycle after mem_done.
  - The CPU must drop mem_req in the mem_done cycle, or it is treated as a new request.
- Minimum latency with ready slaves:
  - read: mem_req to mem_done = 4 cycles (IDLE, RD_ADDR, RD_DATA, DONE);
  - write: 4 cycles.
- R/B beats arriving in unexpected states are not accepted, because READY is low.

Optional Feature:
- Macro: CPU_AXI_POSTED_WRITE_EN.
- Defined:
  - A write pulses mem_done (mem_err=0) in the cycle after both AW and W have handshaken.
  - The FSM still waits in WR_RESP for B before returning to IDLE.
  - A new mem_req is held off until then.
  - An erroring B sets posted_err; it is sticky until rst.
- Undefined:
  - Writes complete only after B, as described in Behaviour.
  - posted_err is tied to 0.

Test Plan:
- Read 0x0000_1006; slave ARREADY=1, RDATA=0xDEADBEEF, RRESP=0, RLAST=1 -> ARADDR_M=0x0000_1004; mem_done on cycle 4; mem_rdata=0xDEADBEEF; mem_err=0.
- Write 0x0000_2000, data 0x12345678, wstrb=4'b0011; WREADY asserted 2 cycles before AWREADY -> WVALID drops first; AWVALID held; BREADY after both; mem_done after B.
- ARREADY held low for 5 cycles -> ARVALID_M stays 1 with ARADDR stable; no mem_done until R.
- Read with RRESP=2'b10, then a second read with RID=MASTER_ID+1 -> mem_err=1 on both completions.
- Assert rst during WR_RESP -> AWVALID/WVALID/BREADY=0 immediately; next read from IDLE completes normally.
- With CPU_AXI_POSTED_WRITE_EN: write with BRESP=2'b11 -> mem_done before B; posted_err=1 after B and stays 1; a queued read is issued only after B.
